frame_writer: RTL and testbench

FRAME_WRITER -- requirements
Module: frame_writer

---
 rtl/frame_writer_if.sv | 25 ++
 rtl/frame_writer.sv | 116 +++++++++++
 tb/tb_frame_writer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_writer_if.sv
// Bundle of producer, display-window and frame-memory port A signals for frame_writer.
// The master side belongs to frame_writer; the slave side is the surrounding system.
interface frame_writer_if;
    logic        start;
    logic [19:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        ready_sig;
    logic        wait_request;
    logic [15:0] address_a;
    logic [19:0] data_a;
    logic        wren_a;
    logic        busy;
    logic        frame_done;

    modport master (
        input  start, in_data, in_valid, ready_sig, wait_request,
        output in_ready, address_a, data_a, wren_a, busy, frame_done
    );

    modport slave (
        output start, in_data, in_valid, ready_sig, wait_request,
        input  in_ready, address_a, data_a, wren_a, busy, frame_done
    );
endinterface

// File: rtl/frame_writer.sv
// Streams FRAME_WORDS pixel words from a small input FIFO into frame memory port A,
// honouring the display write window (ready_sig) and memory stalls (wait_request).
module frame_writer #(
    parameter int FRAME_WORDS = 49152,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic          clk,
    input  logic          reset,
    frame_writer_if.master bus
);
    localparam int               PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   DEPTH     = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [15:0]      LAST_ADDR = 16'(FRAME_WORDS - 1);
    localparam logic [16:0]      FRAME_LEN = 17'(FRAME_WORDS);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [19:0]      r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic [16:0]      r_pushCount;
    logic [15:0]      r_addr;
    logic [19:0]      r_data;
    logic             r_wren;

    logic             w_start;
    logic             w_full;
    logic             w_empty;
    logic             w_last;
    logic             w_inReady;
    logic             w_push;
    logic             w_pop;
    logic             w_issue;
    logic             w_chain;
    logic [PTR_W-1:0] w_nextRdPtr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    // The head word stays in the FIFO until its write completes, so a chained
    // write needs a second word already resident (occupancy above one).
    always_comb begin
        w_nextState = r_state;
        w_start     = (r_state == IDLE) && bus.start;
        w_full      = (r_count == DEPTH);
        w_empty     = (r_count == '0);
        w_last      = (r_addr == LAST_ADDR);
        w_inReady   = (r_state == WRITE) && !w_full && (r_pushCount < FRAME_LEN);
        w_push      = bus.in_valid && w_inReady;
        w_pop       = r_wren && !bus.wait_request;
        w_issue     = (r_state == WRITE) && !r_wren && !w_empty && bus.ready_sig;
        w_chain     = w_pop && !w_last && (r_count > CNT_ONE) && bus.ready_sig;
        w_nextRdPtr = r_rdPtr + PTR_ONE;
        case (r_state)
            IDLE:    if (bus.start) w_nextState = WRITE;
            WRITE:   if (w_pop && w_last) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wrPtr] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_pushCount <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_wren      <= 1'b0;
        end else begin
            if (w_start) begin
                r_wrPtr     <= '0;
                r_rdPtr     <= '0;
                r_count     <= '0;
                r_pushCount <= '0;
                r_addr      <= '0;
            end else begin
                if (w_push) begin
                    r_wrPtr     <= r_wrPtr + PTR_ONE;
                    r_pushCount <= r_pushCount + 17'd1;
                end
                if (w_pop) r_rdPtr <= w_nextRdPtr;
                if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
                else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;
                // The address never advances past the last word of the frame.
                if (w_pop && !w_last) r_addr <= r_addr + 16'd1;
            end
            if (w_issue) begin
                r_wren <= 1'b1;
                r_data <= r_fifo[r_rdPtr];
            end else if (w_pop) begin
                r_wren <= w_chain;
                if (w_chain) r_data <= r_fifo[w_nextRdPtr];
            end
        end
    end

    assign bus.in_ready   = w_inReady;
    assign bus.address_a  = r_addr;
    assign bus.data_a     = r_data;
    assign bus.wren_a     = r_wren;
    assign bus.busy       = (r_state != IDLE);
    assign bus.frame_done = (r_state == DONE);
endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer: scoreboard of accepted words against memory
// writes, a table of frame scenarios, and hand-written multi-cycle corner cases.
module tb_frame_writer;
    localparam int FW = 8;
    localparam int FD = 4;

    typedef struct {
        logic [15:0] addr;
        logic [19:0] data;
    } exp_t;

    typedef struct {
        int stallAddr;
        int stallCycles;
        int readyLowCycles;
        int expHold;
    } vec_t;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic tbWait = 1'b0;

    frame_writer_if bus();

    frame_writer #(.FRAME_WORDS(FW), .FIFO_DEPTH(FD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.wait_request = tbWait;

    always #5 clk = ~clk;

    exp_t        sb[$];
    exp_t        monEntry;
    vec_t        vecs[3];
    vec_t        plainVec;
    int          checks    = 0;
    int          errors    = 0;
    int          pushIdx   = 0;
    int          stallAddr = -1;
    int          stallLeft = 0;
    int          holdCnt   = 0;
    int          doneCnt   = 0;
    logic        prevStall = 1'b0;
    logic        prevDone  = 1'b0;
    logic [15:0] prevAddr  = '0;
    logic [19:0] prevData  = '0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Memory model: stalls the write at stallAddr for stallLeft cycles.
    always @(posedge clk) begin
        #1;
        if (bus.wren_a && int'(bus.address_a) == stallAddr && stallLeft > 0) begin
            tbWait = 1'b1;
            stallLeft--;
        end else begin
            tbWait = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            prevStall = 1'b0;
            prevDone  = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stall_wren", bus.wren_a, 1);
                checkOutput("stall_addr", bus.address_a, prevAddr);
                checkOutput("stall_data", bus.data_a, prevData);
            end
            if (prevDone) begin
                checkOutput("done_single_pulse", bus.frame_done, 0);
                checkOutput("busy_after_done", bus.busy, 0);
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back('{16'(pushIdx), bus.in_data});
                pushIdx++;
            end
            if (bus.wren_a) begin
                checkOutput("addr_in_range", (bus.address_a < 16'(FW)), 1);
                if (int'(bus.address_a) == stallAddr) holdCnt++;
            end
            if (bus.wren_a && !bus.wait_request) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr %0d, expected no write", bus.address_a);
                end else begin
                    monEntry = sb.pop_front();
                    checkOutput("write_addr", bus.address_a, monEntry.addr);
                    checkOutput("write_data", bus.data_a, monEntry.data);
                end
            end
            if (bus.frame_done) doneCnt++;
            prevStall = bus.wren_a && bus.wait_request;
            prevAddr  = bus.address_a;
            prevData  = bus.data_a;
            prevDone  = bus.frame_done;
        end
    end

    task automatic startFrame();
        @(posedge clk);
        #1;
        checkOutput("busy_idle", bus.busy, 0);
        pushIdx   = 0;
        holdCnt   = 0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        checkOutput("busy_after_start", bus.busy, 1);
    endtask

    task automatic offerWords(input int n, input int maxCycles, output int acc);
        int   cyc;
        logic hs;
        cyc = 0;
        acc = 0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 20'($urandom);
        while (acc < n && cyc < maxCycles) begin
            @(negedge clk);
            hs = bus.in_ready;
            if (acc >= FW) checkOutput("in_ready_after_frame_full", bus.in_ready, 0);
            @(posedge clk);
            #1;
            cyc++;
            if (hs) begin
                acc++;
                bus.in_data = 20'($urandom);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.frame_done && cyc < 300);
        checkOutput({name, "_done_seen"}, bus.frame_done, 1);
        @(negedge clk);
        @(negedge clk);
        checkOutput({name, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        int acc;
        int d0;
        d0            = doneCnt;
        stallAddr     = v.stallAddr;
        stallLeft     = v.stallCycles;
        bus.ready_sig = (v.readyLowCycles == 0);
        startFrame();
        fork
            offerWords(FW, 300, acc);
            begin
                repeat (v.readyLowCycles) @(posedge clk);
                #1;
                bus.ready_sig = 1'b1;
            end
        join
        checkOutput({name, "_accepted"}, acc, FW);
        waitDone(name);
        checkOutput({name, "_hold_cycles"}, holdCnt, v.expHold);
        checkOutput({name, "_done_count"}, doneCnt - d0, 1);
    endtask

    initial begin
        int acc;
        int d0;
        int cyc;

        vecs[0]  = '{2, 0, 0, 1};
        vecs[1]  = '{2, 3, 0, 4};
        vecs[2]  = '{5, 1, 6, 2};
        plainVec = '{-1, 0, 0, 0};

        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.ready_sig = 1'b1;

        #2 reset = 1'b0;
        #1;
        checkOutput("reset_wren", bus.wren_a, 0);
        checkOutput("reset_addr", bus.address_a, 0);
        checkOutput("reset_data", bus.data_a, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_in_ready", bus.in_ready, 0);
        checkOutput("reset_frame_done", bus.frame_done, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 3; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Window closed while the FIFO fills, then a burst of four writes.
        d0            = doneCnt;
        stallAddr     = -1;
        bus.ready_sig = 1'b0;
        startFrame();
        offerWords(FD, 20, acc);
        checkOutput("blocked_accepted", acc, FD);
        @(negedge clk);
        checkOutput("blocked_wren", bus.wren_a, 0);
        checkOutput("blocked_in_ready_full", bus.in_ready, 0);
        @(posedge clk);
        #1 bus.ready_sig = 1'b1;
        @(posedge clk);
        for (int i = 0; i < FD; i++) begin
            @(negedge clk);
            checkOutput($sformatf("burst_wren_%0d", i), bus.wren_a, 1);
            checkOutput($sformatf("burst_addr_%0d", i), bus.address_a, i);
        end
        @(negedge clk);
        checkOutput("burst_end_wren", bus.wren_a, 0);
        offerWords(FW - FD, 50, acc);
        checkOutput("burst_rest_accepted", acc, FW - FD);
        waitDone("burst");
        checkOutput("burst_done_count", doneCnt - d0, 1);

        // A second start mid-frame must not restart the address sequence.
        d0 = doneCnt;
        startFrame();
        fork
            offerWords(FW, 300, acc);
            begin
                repeat (4) @(posedge clk);
                #1 bus.start = 1'b1;
                @(posedge clk);
                #1 bus.start = 1'b0;
                @(negedge clk);
                checkOutput("restart_busy", bus.busy, 1);
            end
        join
        checkOutput("restart_accepted", acc, FW);
        waitDone("restart");
        checkOutput("restart_done_count", doneCnt - d0, 1);

        // Reset while a write is stalled, then a clean frame from address 0.
        stallAddr = 1;
        stallLeft = 1000;
        startFrame();
        offerWords(FD, 50, acc);
        cyc = 0;
        while (!(bus.wren_a && bus.address_a == 16'd1) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("midreset_stall_reached", bus.wren_a && bus.address_a == 16'd1, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("midreset_wren", bus.wren_a, 0);
        checkOutput("midreset_addr", bus.address_a, 0);
        checkOutput("midreset_data", bus.data_a, 0);
        checkOutput("midreset_busy", bus.busy, 0);
        checkOutput("midreset_in_ready", bus.in_ready, 0);
        checkOutput("midreset_frame_done", bus.frame_done, 0);
        stallLeft = 0;
        stallAddr = -1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        applyStimulus(plainVec, "postreset");

        // Producer offers more words than one frame holds.
        d0 = doneCnt;
        startFrame();
        offerWords(FW + 2, 60, acc);
        checkOutput("overflow_accepted", acc, FW);
        checkOutput("overflow_done_count", doneCnt - d0, 1);
        checkOutput("overflow_sb_empty", sb.size(), 0);
        checkOutput("overflow_busy", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
